// File: rtl/kinase_ctrl_pkg.sv
// kinase_ctrl_pkg: shared constants, pump tables and types for the kinase valve sequencer
package kinase_ctrl_pkg;

    localparam logic [12:0] SAFE_CTRL_A = 13'h1FFF;
    localparam logic [3:0]  SAFE_CTRL_S = 4'hF;
    localparam logic [2:0]  SAFE_PUMP_A = 3'b111;
    localparam logic [1:0]  SAFE_PUMP_B = 2'b11;

    localparam logic [2:0] PUMP_A_SEQ [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};
    localparam logic [1:0] PUMP_B_SEQ [2] = '{2'b01, 2'b10};

    typedef struct packed {
        logic [12:0] valve;
        logic [3:0]  sel;
        logic        pa_en;
        logic        pa_dir;
        logic        pb_en;
    } step_cmd_t;

    typedef enum logic [1:0] {IDLE, SETTLE, RUN, PARK} seq_state_e;

    function automatic logic [2:0] pa_step(input logic [2:0] idx, input logic dir);
        return dir ? (idx == 3'd0 ? 3'd5 : idx - 3'd1) : (idx == 3'd5 ? 3'd0 : idx + 3'd1);
    endfunction

endpackage

// File: rtl/kinase_valve_sequencer_tick_gen.sv
// tick_gen: prescaler emitting a one-cycle tick every PRESCALE cycles, restartable by clr
module tick_gen #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE);

    logic [CW-1:0] cnt;

    assign tick = cnt == CW'(PRESCALE - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (clr || tick) ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/kinase_valve_sequencer.sv
// kinase_valve_sequencer: timed valve/pump step sequencer driving the kinase chip control pads
module kinase_valve_sequencer
    import kinase_ctrl_pkg::*;
#(
    parameter int PRESCALE   = 1000,
    parameter int DUR_W      = 16,
    parameter int SETTLE_TKS = 4,
    parameter int PUMP_DIV   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [12:0]      cmd_valve,
    input  logic [3:0]       cmd_sel,
    input  logic             cmd_pa_en,
    input  logic             cmd_pa_dir,
    input  logic             cmd_pb_en,
    input  logic [DUR_W-1:0] cmd_dur,
    input  logic             abort,
    output logic [12:0]      ctrl_a,
    output logic [3:0]       ctrl_s,
    output logic [2:0]       pump_a,
    output logic [1:0]       pump_b,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int SW = $clog2(SETTLE_TKS + 1);
    localparam int VW = $clog2(PUMP_DIV + 1);

    seq_state_e       state_q, state_d;
    step_cmd_t        cmd_q;
    logic [SW-1:0]    settle_cnt;
    logic [DUR_W-1:0] dur_cnt;
    logic [VW-1:0]    div_cnt;
    logic [2:0]       pa_idx, pa_idx_d;
    logic             pb_idx, pb_idx_d;
    logic             tick, accept, adv, pump_on;
    logic [2:0]       pump_a_d;
    logic [1:0]       pump_b_d;
    logic             busy_d, done_d, aborted_d;

    assign cmd_ready = state_q == IDLE;
    assign accept    = cmd_ready && cmd_valid;
    assign adv       = state_q == RUN && tick && div_cnt == VW'(PUMP_DIV - 1);
    assign pa_idx_d  = adv ? pa_step(pa_idx, cmd_q.pa_dir) : pa_idx;
    assign pb_idx_d  = pb_idx ^ adv;
    // valve/select pads are the latched command itself, so they hold through IDLE
    assign ctrl_a    = cmd_q.valve;
    assign ctrl_s    = cmd_q.sel;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cmd_valid ? SETTLE : IDLE;
            SETTLE:  state_d = abort ? PARK : (tick && settle_cnt == SW'(SETTLE_TKS - 1)) ? RUN : SETTLE;
            RUN:     state_d = (abort || dur_cnt == '0 || (tick && dur_cnt == DUR_W'(1))) ? PARK : RUN;
            default: state_d = IDLE;
        endcase
    end

    // outputs are computed from the next state so the pads change on the same edge as the FSM
    always_comb begin
        pump_on   = state_d == RUN && dur_cnt != '0;
        pump_a_d  = (pump_on && cmd_q.pa_en) ? PUMP_A_SEQ[pa_idx_d] : SAFE_PUMP_A;
        pump_b_d  = (pump_on && cmd_q.pb_en) ? PUMP_B_SEQ[pb_idx_d] : SAFE_PUMP_B;
        busy_d    = state_d != IDLE;
        done_d    = state_d == PARK;
        aborted_d = done_d && abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= '{valve: SAFE_CTRL_A, sel: SAFE_CTRL_S, pa_en: 1'b0, pa_dir: 1'b0, pb_en: 1'b0};
            settle_cnt <= '0;
            dur_cnt    <= '0;
            div_cnt    <= '0;
            pa_idx     <= '0;
            pb_idx     <= 1'b0;
            pump_a     <= SAFE_PUMP_A;
            pump_b     <= SAFE_PUMP_B;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            pump_a  <= pump_a_d;
            pump_b  <= pump_b_d;
            busy    <= busy_d;
            done    <= done_d;
            aborted <= aborted_d;
            pa_idx  <= pa_idx_d;
            pb_idx  <= pb_idx_d;
            if (accept) begin
                cmd_q      <= '{valve: cmd_valve, sel: cmd_sel, pa_en: cmd_pa_en, pa_dir: cmd_pa_dir, pb_en: cmd_pb_en};
                settle_cnt <= '0;
                dur_cnt    <= cmd_dur;
                div_cnt    <= '0;
                pa_idx     <= '0;
                pb_idx     <= 1'b0;
            end else if (tick && state_q == SETTLE) begin
                settle_cnt <= settle_cnt + SW'(1);
            end else if (tick && state_q == RUN) begin
                dur_cnt <= dur_cnt - DUR_W'(dur_cnt != '0);
                div_cnt <= (div_cnt == VW'(PUMP_DIV - 1)) ? '0 : div_cnt + VW'(1);
            end
        end
    end

endmodule
